// File: rtl/fpu_ch_arbiter_if.sv
// Channel-side and FPU-side signal bundle of the multi-channel FPU front-end.
// The master modport is the arbiter's view; slave is the surrounding lanes and FPU.
interface fpu_ch_arbiter_if #(
  parameter int DWIDTH       = 16,
  parameter int NUM_OPERANDS = 3,
  parameter int NUM_CH       = 4,
  parameter int CTRLW        = 16,
  parameter int TAGW         = 4
);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                                   flush_i;
  logic [NUM_CH-1:0]                      ch_valid_i;
  logic [NUM_CH-1:0]                      ch_ready_o;
  logic [NUM_CH*NUM_OPERANDS*DWIDTH-1:0]  ch_operands_i;
  logic [NUM_CH*CTRLW-1:0]                ch_ctrl_i;
  logic [NUM_CH*TAGW-1:0]                 ch_tag_i;
  logic                                   fpu_valid_o;
  logic                                   fpu_ready_i;
  logic [NUM_OPERANDS*DWIDTH-1:0]         fpu_operands_o;
  logic [CTRLW-1:0]                       fpu_ctrl_o;
  logic [CHW+TAGW-1:0]                    fpu_tag_o;
  logic                                   fpu_flush_o;
  logic                                   fpu_rvalid_i;
  logic                                   fpu_rready_o;
  logic [DWIDTH-1:0]                      fpu_result_i;
  logic [4:0]                             fpu_status_i;
  logic [CHW+TAGW-1:0]                    fpu_rtag_i;
  logic                                   fpu_busy_i;
  logic [NUM_CH-1:0]                      rsp_valid_o;
  logic [NUM_CH-1:0]                      rsp_ready_i;
  logic [DWIDTH-1:0]                      rsp_result_o;
  logic [4:0]                             rsp_status_o;
  logic [TAGW-1:0]                        rsp_tag_o;
  logic                                   busy_o;

  modport master (
    input  flush_i, ch_valid_i, ch_operands_i, ch_ctrl_i, ch_tag_i, fpu_ready_i,
           fpu_rvalid_i, fpu_result_i, fpu_status_i, fpu_rtag_i, fpu_busy_i, rsp_ready_i,
    output ch_ready_o, fpu_valid_o, fpu_operands_o, fpu_ctrl_o, fpu_tag_o, fpu_flush_o,
           fpu_rready_o, rsp_valid_o, rsp_result_o, rsp_status_o, rsp_tag_o, busy_o
  );

  modport slave (
    output flush_i, ch_valid_i, ch_operands_i, ch_ctrl_i, ch_tag_i, fpu_ready_i,
           fpu_rvalid_i, fpu_result_i, fpu_status_i, fpu_rtag_i, fpu_busy_i, rsp_ready_i,
    input  ch_ready_o, fpu_valid_o, fpu_operands_o, fpu_ctrl_o, fpu_tag_o, fpu_flush_o,
           fpu_rready_o, rsp_valid_o, rsp_result_o, rsp_status_o, rsp_tag_o, busy_o
  );
endinterface

// File: rtl/fpu_ch_arbiter.sv
// Round-robin front-end sharing one FPU issue port among NUM_CH requesters; results
// are steered back by the channel id carried in the upper bits of the FPU tag.
module fpu_ch_arbiter #(
  parameter int DWIDTH       = 16,
  parameter int NUM_OPERANDS = 3,
  parameter int NUM_CH       = 4,
  parameter int CTRLW        = 16,
  parameter int TAGW         = 4,
  parameter int MAX_OUTST    = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  fpu_ch_arbiter_if.master bus
);
  localparam int CHW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNTW = $clog2(MAX_OUTST + 1);
  localparam int OPW  = NUM_OPERANDS * DWIDTH;

  logic [CNTW-1:0]     cnt_q [NUM_CH];
  logic [CHW-1:0]      rr_ptr_q;
  logic                issue_vld_q;
  logic [OPW-1:0]      issue_ops_q;
  logic [CTRLW-1:0]    issue_ctrl_q;
  logic [CHW+TAGW-1:0] issue_tag_q;

  logic [NUM_CH-1:0]   eligible;
  logic                grant_found;
  logic [CHW-1:0]      grant;
  logic                accept;
  logic [CHW-1:0]      rsp_ch;
  logic                rsp_ch_ok;
  logic                rsp_hs;
  logic [NUM_CH-1:0]   cnt_inc;
  logic [NUM_CH-1:0]   cnt_dec;
  logic                cnt_any;

  // First eligible channel at or after the pointer, wrapping.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant       = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      eligible[c] = bus.ch_valid_i[c] && (cnt_q[c] < CNTW'(MAX_OUTST));
    end
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_CH;
      if (!grant_found && eligible[idx]) begin
        grant_found = 1'b1;
        grant       = CHW'(idx);
      end
    end
  end

  // The issue register refills in the same cycle it drains.
  assign accept = rst_ni && !bus.flush_i && grant_found && (!issue_vld_q || bus.fpu_ready_i);

  always_comb begin
    bus.ch_ready_o = '0;
    if (accept) bus.ch_ready_o[grant] = 1'b1;
  end

  assign rsp_ch    = bus.fpu_rtag_i[TAGW +: CHW];
  assign rsp_ch_ok = int'(rsp_ch) < NUM_CH;
  assign rsp_hs    = rst_ni && !bus.flush_i && rsp_ch_ok && bus.fpu_rvalid_i && bus.rsp_ready_i[rsp_ch];

  always_comb begin
    bus.rsp_valid_o = '0;
    if (rst_ni && !bus.flush_i && rsp_ch_ok) bus.rsp_valid_o[rsp_ch] = bus.fpu_rvalid_i;
  end

  // Unroutable ids, flush and reset all drain the FPU result port.
  assign bus.fpu_rready_o = !rst_ni || bus.flush_i || !rsp_ch_ok || bus.rsp_ready_i[rsp_ch];
  assign bus.rsp_result_o = bus.fpu_result_i;
  assign bus.rsp_status_o = bus.fpu_status_i;
  assign bus.rsp_tag_o    = bus.fpu_rtag_i[TAGW-1:0];

  always_comb begin
    cnt_any = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      cnt_inc[c] = accept && (grant == CHW'(c));
      cnt_dec[c] = rsp_hs && (rsp_ch == CHW'(c)) && (cnt_q[c] != '0);
      cnt_any    = cnt_any || (cnt_q[c] != '0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || bus.flush_i) begin
      issue_vld_q <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) cnt_q[c] <= '0;
      if (!rst_ni) rr_ptr_q <= '0;
    end else begin
      if (accept) begin
        issue_vld_q <= 1'b1;
        rr_ptr_q    <= (int'(grant) == NUM_CH - 1) ? '0 : grant + 1'b1;
      end else if (bus.fpu_ready_i) begin
        issue_vld_q <= 1'b0;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (cnt_inc[c] && !cnt_dec[c])      cnt_q[c] <= cnt_q[c] + 1'b1;
        else if (cnt_dec[c] && !cnt_inc[c]) cnt_q[c] <= cnt_q[c] - 1'b1;
      end
    end
  end

  // NOTE: payload registers carry no reset; fpu_valid_o qualifies them.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      issue_ops_q  <= bus.ch_operands_i[grant*OPW +: OPW];
      issue_ctrl_q <= bus.ch_ctrl_i[grant*CTRLW +: CTRLW];
      issue_tag_q  <= {grant, bus.ch_tag_i[grant*TAGW +: TAGW]};
    end
  end

  assign bus.fpu_valid_o    = issue_vld_q;
  assign bus.fpu_operands_o = issue_ops_q;
  assign bus.fpu_ctrl_o     = issue_ctrl_q;
  assign bus.fpu_tag_o      = issue_tag_q;
  assign bus.fpu_flush_o    = bus.flush_i;
  assign bus.busy_o         = issue_vld_q || bus.fpu_busy_i || cnt_any;
endmodule

// File: tb/tb_fpu_ch_arbiter.sv
// Bench for fpu_ch_arbiter: directed scenarios plus random traffic against a
// transaction-level model (per-channel in-flight counts, rotating priority, issue slot).
module tb_fpu_ch_arbiter;
  localparam int DW = 16, NOP = 3, NC = 4, CW = 16, TW = 4, MAXO = 4;
  localparam int CHW = 2;
  localparam int OPW = NOP * DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fpu_ch_arbiter_if #(.DWIDTH(DW), .NUM_OPERANDS(NOP), .NUM_CH(NC), .CTRLW(CW), .TAGW(TW)) bus ();
  fpu_ch_arbiter #(.DWIDTH(DW), .NUM_OPERANDS(NOP), .NUM_CH(NC), .CTRLW(CW), .TAGW(TW),
                   .MAX_OUTST(MAXO)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  // Reference model state.
  int                  m_cnt [NC];
  int                  m_ptr;
  bit                  m_full;
  logic [OPW-1:0]      m_ops;
  logic [CW-1:0]       m_ctrl;
  logic [CHW+TW-1:0]   m_tag;
  logic [CHW+TW-1:0]   inflight [$];

  function automatic int exp_grant();
    if (bus.flush_i || (m_full && !bus.fpu_ready_i)) return -1;
    for (int k = 0; k < NC; k++) begin
      int c = (m_ptr + k) % NC;
      if (bus.ch_valid_i[c] && m_cnt[c] < MAXO) return c;
    end
    return -1;
  endfunction

  function automatic logic [NC-1:0] exp_ready();
    int g = exp_grant();
    return (g < 0) ? '0 : (NC'(1) << g);
  endfunction

  function automatic int rsp_ch();
    return int'(bus.fpu_rtag_i[TW +: CHW]);
  endfunction

  function automatic logic [NC-1:0] exp_rsp_valid();
    return (!bus.flush_i && bus.fpu_rvalid_i) ? (NC'(1) << rsp_ch()) : '0;
  endfunction

  function automatic logic exp_rready();
    return bus.flush_i || bus.rsp_ready_i[rsp_ch()];
  endfunction

  function automatic logic exp_busy();
    int total = 0;
    for (int c = 0; c < NC; c++) total += m_cnt[c];
    return m_full || bus.fpu_busy_i || (total != 0);
  endfunction

  // One clock: advance the model with the inputs present before the edge, return at negedge.
  task automatic tick();
    int  g  = exp_grant();
    int  rc = rsp_ch();
    bit  hs = rst_n && !bus.flush_i && bus.fpu_rvalid_i && bus.rsp_ready_i[rc];
    @(posedge clk);
    if (!rst_n || bus.flush_i) begin
      for (int c = 0; c < NC; c++) m_cnt[c] = 0;
      m_full = 0;
      inflight.delete();
      if (!rst_n) m_ptr = 0;
    end else begin
      if (m_full && bus.fpu_ready_i) inflight.push_back(m_tag);
      if (hs) begin
        int idx [$] = inflight.find_first_index(x) with (x == bus.fpu_rtag_i);
        if (idx.size() > 0) inflight.delete(idx[0]);
        if (m_cnt[rc] > 0) m_cnt[rc]--;
      end
      if (g >= 0) begin
        m_cnt[g]++;
        m_full = 1;
        m_ops  = bus.ch_operands_i[g*OPW +: OPW];
        m_ctrl = bus.ch_ctrl_i[g*CW +: CW];
        m_tag  = {CHW'(g), bus.ch_tag_i[g*TW +: TW]};
        m_ptr  = (g + 1) % NC;
      end else if (bus.fpu_ready_i) begin
        m_full = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic rand_payload();
    for (int i = 0; i < NC*OPW/32; i++) bus.ch_operands_i[i*32 +: 32] = $urandom;
    for (int i = 0; i < NC*CW/32; i++)  bus.ch_ctrl_i[i*32 +: 32] = $urandom;
    bus.ch_tag_i = 16'($urandom);
  endtask

  task automatic quiesce();
    bus.ch_valid_i = '0; bus.fpu_rvalid_i = 1'b0; bus.rsp_ready_i = '0;
    bus.fpu_busy_i = 1'b0; bus.fpu_ready_i = 1'b1; bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
  endtask

  task automatic test_reset();
    bus.ch_valid_i = '1; bus.fpu_ready_i = 1'b1; bus.fpu_rvalid_i = 1'b1;
    bus.rsp_ready_i = '1; bus.fpu_rtag_i = 6'h12;
    rand_payload();
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (bus.ch_ready_o !== '0) begin
        miscompares++; $display("FAIL reset_ch_ready got=%b want=0000", bus.ch_ready_o);
      end
      vectors++;
      if (bus.rsp_valid_o !== '0) begin
        miscompares++; $display("FAIL reset_rsp_valid got=%b want=0000", bus.rsp_valid_o);
      end
      tick();
    end
    bus.ch_valid_i = '0; bus.fpu_rvalid_i = 1'b0; bus.rsp_ready_i = '0;
    rst_n = 1'b1;
    #1;
    vectors++;
    if (bus.fpu_valid_o !== 1'b0) begin
      miscompares++; $display("FAIL reset_fpu_valid got=%b want=0", bus.fpu_valid_o);
    end
    vectors++;
    if (bus.busy_o !== 1'b0) begin
      miscompares++; $display("FAIL reset_busy got=%b want=0", bus.busy_o);
    end
  endtask

  task automatic test_single();
    logic [OPW-1:0] ops;
    logic [CW-1:0]  ctrl;
    logic [DW-1:0]  res;
    rand_payload();
    bus.ch_tag_i[3:0] = 4'h5;
    ops  = bus.ch_operands_i[0 +: OPW];
    ctrl = bus.ch_ctrl_i[0 +: CW];
    bus.ch_valid_i = 4'b0001; bus.fpu_ready_i = 1'b1;
    #1;
    vectors++;
    if (bus.ch_ready_o !== 4'b0001) begin
      miscompares++; $display("FAIL single_ready got=%b want=0001", bus.ch_ready_o);
    end
    tick();
    bus.ch_valid_i = '0;
    #1;
    vectors++;
    if (bus.fpu_valid_o !== 1'b1 || bus.fpu_tag_o !== {2'd0, 4'h5}) begin
      miscompares++;
      $display("FAIL single_issue got v=%b tag=%h want v=1 tag=05", bus.fpu_valid_o, bus.fpu_tag_o);
    end
    vectors++;
    if (bus.fpu_operands_o !== ops || bus.fpu_ctrl_o !== ctrl) begin
      miscompares++;
      $display("FAIL single_payload got=%h/%h want=%h/%h", bus.fpu_operands_o, bus.fpu_ctrl_o, ops, ctrl);
    end
    tick();
    res = 16'($urandom);
    bus.fpu_rvalid_i = 1'b1; bus.fpu_rtag_i = {2'd0, 4'h9}; bus.fpu_result_i = res;
    bus.fpu_status_i = 5'h13; bus.rsp_ready_i = 4'b0001;
    #1;
    vectors++;
    if (bus.rsp_valid_o !== 4'b0001 || bus.fpu_rready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL single_rsp got v=%b rr=%b want v=0001 rr=1", bus.rsp_valid_o, bus.fpu_rready_o);
    end
    vectors++;
    if (bus.rsp_result_o !== res || bus.rsp_status_o !== 5'h13 || bus.rsp_tag_o !== 4'h9) begin
      miscompares++;
      $display("FAIL single_rsp_data got=%h/%h/%h want=%h/13/9", bus.rsp_result_o,
               bus.rsp_status_o, bus.rsp_tag_o, res);
    end
    tick();
    bus.fpu_rvalid_i = 1'b0; bus.rsp_ready_i = '0;
    #1;
    vectors++;
    if (bus.busy_o !== 1'b0 || bus.fpu_valid_o !== 1'b0) begin
      miscompares++; $display("FAIL single_idle got busy=%b v=%b want 0/0", bus.busy_o, bus.fpu_valid_o);
    end
  endtask

  task automatic test_round_robin();
    int expect_ch;
    quiesce();
    bus.ch_valid_i = '1; bus.fpu_ready_i = 1'b1;
    expect_ch = m_ptr;
    for (int i = 0; i < 12; i++) begin
      rand_payload();
      #1;
      vectors++;
      if (bus.ch_ready_o !== (NC'(1) << expect_ch)) begin
        miscompares++;
        $display("FAIL rr_grant cycle %0d got=%b want ch%0d", i, bus.ch_ready_o, expect_ch);
      end
      if (i > 0) begin
        vectors++;
        if (bus.fpu_valid_o !== 1'b1 || bus.fpu_tag_o !== m_tag || bus.fpu_operands_o !== m_ops) begin
          miscompares++;
          $display("FAIL rr_issue cycle %0d got tag=%h want tag=%h", i, bus.fpu_tag_o, m_tag);
        end
      end
      tick();
      expect_ch = (expect_ch + 1) % NC;
    end
  endtask

  task automatic test_outstanding();
    quiesce();
    bus.fpu_ready_i = 1'b1;
    bus.ch_valid_i = 4'b0100;
    for (int i = 0; i < MAXO; i++) begin
      rand_payload();
      #1;
      vectors++;
      if (bus.ch_ready_o !== 4'b0100) begin
        miscompares++; $display("FAIL outst_fill %0d got=%b want=0100", i, bus.ch_ready_o);
      end
      tick();
    end
    bus.ch_valid_i = 4'b0110;
    #1;
    vectors++;
    if (bus.ch_ready_o !== 4'b0010) begin
      miscompares++; $display("FAIL outst_block got=%b want=0010", bus.ch_ready_o);
    end
    tick();
    bus.fpu_rvalid_i = 1'b1; bus.fpu_rtag_i = {2'd2, bus.ch_tag_i[2*TW +: TW]};
    bus.rsp_ready_i = 4'b0100;
    #1;
    vectors++;
    if (bus.ch_ready_o !== 4'b0010 || bus.rsp_valid_o !== 4'b0100) begin
      miscompares++;
      $display("FAIL outst_rsp got rdy=%b rv=%b want 0010/0100", bus.ch_ready_o, bus.rsp_valid_o);
    end
    tick();
    bus.fpu_rvalid_i = 1'b0; bus.rsp_ready_i = '0;
    #1;
    vectors++;
    if (bus.ch_ready_o !== 4'b0100) begin
      miscompares++; $display("FAIL outst_release got=%b want=0100", bus.ch_ready_o);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [OPW-1:0] held;
    logic [OPW-1:0] next_ops;
    quiesce();
    bus.fpu_ready_i = 1'b0; bus.ch_valid_i = 4'b0001;
    rand_payload();
    held = bus.ch_operands_i[0 +: OPW];
    #1;
    vectors++;
    if (bus.ch_ready_o !== 4'b0001) begin
      miscompares++; $display("FAIL bp_first got=%b want=0001", bus.ch_ready_o);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      rand_payload();
      #1;
      vectors++;
      if (bus.ch_ready_o !== '0 || bus.fpu_valid_o !== 1'b1 || bus.fpu_operands_o !== held) begin
        miscompares++;
        $display("FAIL bp_stall %0d got rdy=%b v=%b ops=%h want 0000/1/%h", i, bus.ch_ready_o,
                 bus.fpu_valid_o, bus.fpu_operands_o, held);
      end
      tick();
    end
    bus.fpu_ready_i = 1'b1;
    next_ops = bus.ch_operands_i[0 +: OPW];
    #1;
    vectors++;
    if (bus.ch_ready_o !== 4'b0001) begin
      miscompares++; $display("FAIL bp_resume got=%b want=0001", bus.ch_ready_o);
    end
    tick();
    bus.ch_valid_i = '0;
    #1;
    vectors++;
    if (bus.fpu_valid_o !== 1'b1 || bus.fpu_operands_o !== next_ops) begin
      miscompares++; $display("FAIL bp_refill got=%h want=%h", bus.fpu_operands_o, next_ops);
    end
    tick();
  endtask

  task automatic test_same_cycle();
    int accepted = 0;
    quiesce();
    bus.fpu_ready_i = 1'b1; bus.ch_valid_i = 4'b0010;
    rand_payload();
    tick();
    tick();
    bus.fpu_rvalid_i = 1'b1; bus.fpu_rtag_i = inflight[0]; bus.rsp_ready_i = 4'b0010;
    #1;
    vectors++;
    if (bus.ch_ready_o !== 4'b0010 || bus.rsp_valid_o !== 4'b0010) begin
      miscompares++;
      $display("FAIL same_cycle_hs got rdy=%b rv=%b want 0010/0010", bus.ch_ready_o, bus.rsp_valid_o);
    end
    tick();
    bus.fpu_rvalid_i = 1'b0; bus.rsp_ready_i = '0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (bus.ch_ready_o[1] === 1'b1) accepted++;
      tick();
    end
    vectors++;
    if (accepted != MAXO - 2) begin
      miscompares++; $display("FAIL same_cycle_count got %0d more accepts want %0d", accepted, MAXO - 2);
    end
  endtask

  task automatic test_flush();
    quiesce();
    bus.fpu_ready_i = 1'b1; bus.ch_valid_i = '1;
    for (int i = 0; i < 3; i++) begin
      rand_payload();
      tick();
    end
    bus.flush_i = 1'b1; bus.fpu_rvalid_i = 1'b1; bus.fpu_rtag_i = inflight[0]; bus.rsp_ready_i = '0;
    #1;
    vectors++;
    if (bus.fpu_flush_o !== 1'b1 || bus.ch_ready_o !== '0) begin
      miscompares++;
      $display("FAIL flush_now got fl=%b rdy=%b want 1/0000", bus.fpu_flush_o, bus.ch_ready_o);
    end
    vectors++;
    if (bus.rsp_valid_o !== '0 || bus.fpu_rready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_drain got rv=%b rr=%b want 0000/1", bus.rsp_valid_o, bus.fpu_rready_o);
    end
    tick();
    bus.flush_i = 1'b0; bus.ch_valid_i = '0; bus.fpu_rvalid_i = 1'b0; bus.fpu_busy_i = 1'b0;
    #1;
    vectors++;
    if (bus.fpu_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_after got v=%b busy=%b want 0/0", bus.fpu_valid_o, bus.busy_o);
    end
    bus.fpu_busy_i = 1'b1;
    #1;
    vectors++;
    if (bus.busy_o !== 1'b1) begin
      miscompares++; $display("FAIL flush_busy_follow got=%b want=1", bus.busy_o);
    end
    bus.fpu_busy_i = 1'b0;
    tick();
  endtask

  task automatic test_random();
    quiesce();
    for (int i = 0; i < 600; i++) begin
      rand_payload();
      bus.ch_valid_i   = 4'($urandom);
      bus.fpu_ready_i  = ($urandom % 4) != 0;
      bus.flush_i      = ($urandom % 60) == 0;
      bus.fpu_busy_i   = ($urandom % 8) == 0;
      bus.rsp_ready_i  = 4'($urandom);
      bus.fpu_result_i = 16'($urandom);
      bus.fpu_status_i = 5'($urandom);
      if (inflight.size() > 0 && ($urandom % 2) == 1) begin
        bus.fpu_rvalid_i = 1'b1;
        bus.fpu_rtag_i   = inflight[$urandom_range(0, inflight.size() - 1)];
      end else begin
        bus.fpu_rvalid_i = 1'b0;
        bus.fpu_rtag_i   = 6'($urandom);
      end
      #1;
      vectors++;
      if (bus.ch_ready_o !== exp_ready()) begin
        miscompares++; $display("FAIL rand_ready %0d got=%b want=%b", i, bus.ch_ready_o, exp_ready());
      end
      vectors++;
      if (bus.rsp_valid_o !== exp_rsp_valid() || bus.fpu_rready_o !== exp_rready()) begin
        miscompares++;
        $display("FAIL rand_rsp %0d got rv=%b rr=%b want rv=%b rr=%b", i, bus.rsp_valid_o,
                 bus.fpu_rready_o, exp_rsp_valid(), exp_rready());
      end
      vectors++;
      if (bus.fpu_valid_o !== m_full ||
          (m_full && (bus.fpu_tag_o !== m_tag || bus.fpu_operands_o !== m_ops || bus.fpu_ctrl_o !== m_ctrl))) begin
        miscompares++;
        $display("FAIL rand_issue %0d got v=%b tag=%h want v=%b tag=%h", i, bus.fpu_valid_o,
                 bus.fpu_tag_o, m_full, m_tag);
      end
      vectors++;
      if (bus.busy_o !== exp_busy() || bus.fpu_flush_o !== bus.flush_i) begin
        miscompares++;
        $display("FAIL rand_busy %0d got busy=%b fl=%b want busy=%b", i, bus.busy_o, bus.fpu_flush_o, exp_busy());
      end
      tick();
    end
  endtask

  initial begin
    for (int c = 0; c < NC; c++) m_cnt[c] = 0;
    m_ptr = 0; m_full = 0;
    bus.flush_i = 1'b0; bus.ch_valid_i = '0; bus.ch_operands_i = '0; bus.ch_ctrl_i = '0;
    bus.ch_tag_i = '0; bus.fpu_ready_i = 1'b0; bus.fpu_rvalid_i = 1'b0; bus.fpu_result_i = '0;
    bus.fpu_status_i = '0; bus.fpu_rtag_i = '0; bus.fpu_busy_i = 1'b0; bus.rsp_ready_i = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_outstanding();
    test_backpressure();
    test_same_cycle();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
